midi_note_parser: RTL and testbench
===================================

Name: midi_note_parser

Overview:
- Upstream stage of the synth voice path: parses a raw MIDI byte stream from the UART receiver.
- Tracks one monophonic voice and emits the active note number plus a gate. The note number drives the tone generator's 8-bit note input, with its valid strobe.
- Handles running status, channel filtering, velocity-0 note-off, and real-time bytes interleaved inside messages.

Parameters:
- CHANNEL, 0, 4-bit MIDI channel (0..15) this voice responds to.
- OMNI, 0, when 1, note messages on every channel are accepted and CHANNEL is ignored.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  8  received MIDI byte
- rx_valid  input  1  single-cycle strobe; rx_data is valid this cycle
- note  output  8  current/last note number, bit 7 always 0
- velocity  output  7  velocity of the last accepted note-on
- gate  output  1  1 while a note is held
- note_valid  output  1  one-cycle pulse when note/gate/velocity change
- byte_err  output  1  one-cycle pulse when a data byte arrives with no running status

Behaviour:
- Reset (rst_n low, asynchronous): note=0, velocity=0, gate=0, note_valid=0, byte_err=0, running status cleared, FSM to IDLE.
- A byte is consumed only in a cycle with rx_valid=1. Bytes arrive at most every cycle; no backpressure.
- All outputs are registered. A message completes on the cycle its final byte is consumed; outputs update on the next clk edge (latency 1).
- Byte classes:
  - Real-time (0xF8..0xFF): ignored entirely. State, running status and the partial data byte are untouched.
  - System common/exclusive (0xF0..0xF7): clears running status; FSM to IDLE. Subsequent data bytes are discarded silently until the next channel status byte.
  - Channel status (0x80..0xEF): latched as running status; data count reset to 0. Any partially received message is abandoned.
  - Data (0x00..0x7F): handled per FSM.
- FSM states:
  - IDLE: no running status. A data byte pulses byte_err and stays in IDLE, except after 0xF0..0xF7, where it is dropped silently.
  - WANT_D1: the next data byte is stored as d1.
    - Status 0xC0/0xD0 (one data byte): the message is complete and is skipped; stay in WANT_D1.
    - All other statuses: go to WANT_D2.
  - WANT_D2: the next data byte is d2; the message completes and the FSM returns to WANT_D1 (running status).
- Message actions (only when the channel matches, or OMNI=1; otherwise the message is parsed and skipped):
  - 0x9n with d2≠0 (note-on): note<=d1, velocity<=d2, gate<=1, note_valid pulse. A new note-on while gate=1 retriggers (last-note priority).
  - 0x8n with any d2, or 0x9n with d2=0 (note-off): if gate=1 and d1==note[6:0], then gate<=0 and note_valid pulses; note and velocity hold. Otherwise no change and no pulse.
  - 0xAn, 0xBn, 0xEn (2 data bytes) and 0xCn, 0xDn (1 data byte): consumed, no output effect.
- Reset mid-message: the partial message is lost; the stream resyncs at the next status byte.

Test Plan:
- Reset then bytes 0x90,0x3C,0x64 -> one cycle after the last byte: note=0x3C, velocity=0x64, gate=1, note_valid high for exactly 1 cycle.
- Running status: 0x90,0x40,0x50 then 0x43,0x50 -> two note_valid pulses, final note=0x43, gate=1; then 0x43,0x00 -> gate=0, note stays 0x43.
- Mismatched note-off: hold 0x45 (0x90,0x45,0x7F), send 0x80,0x40,0x00 -> no pulse, gate stays 1. Then 0x80,0x45,0x00 -> gate=0, pulse.
- Real-time interleave: 0x90,0xF8,0x3C,0xFE,0x64 -> same result as scenario 1; no error.
- Channel filter, CHANNEL=0: 0x91,0x3C,0x64 -> no change. Then 0xC0,0x05,0x90,0x30,0x10 -> only the last message applies (note=0x30). With OMNI=1, the 0x91 message applies.
- Error/recovery: after reset, byte 0x3C -> byte_err pulse, outputs unchanged. 0xF0,0x01,0x02,0xF7 -> no err, no change. Assert rst_n low after 0x90,0x3C -> all outputs 0; the following 0x64 -> byte_err pulse.

Source files
------------

// File: rtl/midi_note_parser.sv
// -----------------------------------------------------------------------------
// midi_note_parser
//
// Parses a raw MIDI byte stream from the UART receiver. It tracks one
// monophonic voice and reports the active note, its velocity and a gate.
// The parser handles running status, channel filtering and velocity-0
// note-off. It also accepts real-time bytes interleaved inside messages.
//
// Parameters
//   CHANNEL    MIDI channel (0..15) this voice responds to
//   OMNI       1: accept note messages on every channel, ignore CHANNEL
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   rx_data    received MIDI byte
//   rx_valid   single-cycle strobe, rx_data is valid this cycle
//   note       current/last note number (bit 7 always 0)
//   velocity   velocity of the last accepted note-on
//   gate       1 while a note is held
//   note_valid one-cycle pulse when note/gate/velocity change
//   byte_err   one-cycle pulse when a data byte arrives with no running status
// -----------------------------------------------------------------------------
module midi_note_parser #(
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter bit         OMNI    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] note,
  output logic [6:0] velocity,
  output logic       gate,
  output logic       note_valid,
  output logic       byte_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WANT_D1 = 2'd1,
    WANT_D2 = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] status_q, status_d;     // running status byte
  logic [6:0] d1_q, d1_d;             // first data byte of the current message
  logic       sys_q, sys_d;           // set after 0xF0..0xF7: drop data silently
  logic [7:0] note_q, note_d;
  logic [6:0] vel_q, vel_d;
  logic       gate_q, gate_d;
  logic       note_valid_q, note_valid_d;
  logic       byte_err_q, byte_err_d;

  // Byte classification. Real-time bytes (0xF8..0xFF) match none of these,
  // so they fall through every branch and leave all state untouched.
  logic       is_data, is_status, is_sys;
  logic [3:0] cmd;
  logic       ch_match, one_byte_msg;

  assign is_data      = rx_valid && !rx_data[7];
  assign is_status    = rx_valid && rx_data[7] && (rx_data[7:4] != 4'hF);
  assign is_sys       = rx_valid && (rx_data[7:3] == 5'b11110);
  assign cmd          = status_q[7:4];
  assign ch_match     = OMNI || (status_q[3:0] == CHANNEL);
  assign one_byte_msg = (cmd == 4'hC) || (cmd == 4'hD);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      status_q     <= 8'd0;
      d1_q         <= 7'd0;
      sys_q        <= 1'b0;
      note_q       <= 8'd0;
      vel_q        <= 7'd0;
      gate_q       <= 1'b0;
      note_valid_q <= 1'b0;
      byte_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      d1_q         <= d1_d;
      sys_q        <= sys_d;
      note_q       <= note_d;
      vel_q        <= vel_d;
      gate_q       <= gate_d;
      note_valid_q <= note_valid_d;
      byte_err_q   <= byte_err_d;
    end
  end

  // Next-state logic: message framing and running status
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    d1_d     = d1_q;
    sys_d    = sys_q;
    if (is_status) begin
      // A new status byte abandons any partial message.
      state_d  = WANT_D1;
      status_d = rx_data;
      sys_d    = 1'b0;
    end else if (is_sys) begin
      state_d  = IDLE;
      status_d = 8'd0;
      sys_d    = 1'b1;
    end else if (is_data) begin
      case (state_q)
        IDLE: ;
        WANT_D1: begin
          d1_d = rx_data[6:0];
          // Program change / channel pressure complete on one data byte.
          if (!one_byte_msg) state_d = WANT_D2;
        end
        WANT_D2: state_d = WANT_D1;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic: act on completed note messages
  always_comb begin
    note_d       = note_q;
    vel_d        = vel_q;
    gate_d       = gate_q;
    note_valid_d = 1'b0;
    byte_err_d   = 1'b0;
    if (is_data) begin
      if (state_q == IDLE && !sys_q) byte_err_d = 1'b1;
      if (state_q == WANT_D2 && ch_match) begin
        if (cmd == 4'h9 && rx_data[6:0] != 7'd0) begin
          // Note-on, last-note priority: retriggers over a held note.
          note_d       = {1'b0, d1_q};
          vel_d        = rx_data[6:0];
          gate_d       = 1'b1;
          note_valid_d = 1'b1;
        end else if ((cmd == 4'h8 || cmd == 4'h9) && gate_q &&
                     d1_q == note_q[6:0]) begin
          // Note-off releases only the note currently sounding.
          gate_d       = 1'b0;
          note_valid_d = 1'b1;
        end
      end
    end
  end

  assign note       = note_q;
  assign velocity   = vel_q;
  assign gate       = gate_q;
  assign note_valid = note_valid_q;
  assign byte_err   = byte_err_q;

endmodule

// File: tb/tb_midi_note_parser.sv
// -----------------------------------------------------------------------------
// tb_midi_note_parser
//
// Directed bench for midi_note_parser. A channel-0 instance and an OMNI
// instance share one byte stream. Each step pushes the expected output
// state to a queue. The bench pops that entry one clock later and compares
// it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_midi_note_parser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;

  logic [7:0] note, o_note;
  logic [6:0] velocity, o_velocity;
  logic       gate, o_gate;
  logic       note_valid, o_note_valid;
  logic       byte_err, o_byte_err;

  always #5 clk = ~clk;

  midi_note_parser #(.CHANNEL(4'd0), .OMNI(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .note(note), .velocity(velocity), .gate(gate),
    .note_valid(note_valid), .byte_err(byte_err)
  );

  midi_note_parser #(.CHANNEL(4'd0), .OMNI(1'b1)) dut_omni (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .note(o_note), .velocity(o_velocity), .gate(o_gate),
    .note_valid(o_note_valid), .byte_err(o_byte_err)
  );

  typedef struct packed {
    logic [7:0] note;
    logic [6:0] vel;
    logic       gate;
    logic       nv;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  int         passed = 0;
  int         total  = 0;

  // Expected held voice state of the channel-0 instance
  logic [7:0] e_note = 8'd0;
  logic [6:0] e_vel  = 7'd0;
  logic       e_gate = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one cycle at a negedge, push the expectation, then pop it and
  // compare after the capturing posedge.
  task automatic drive(input logic v, input logic [7:0] b, input logic nv, input logic err,
                       input string tag);
    exp_t e;
    rx_valid = v;
    rx_data  = b;
    sb.push_back('{note: e_note, vel: e_vel, gate: e_gate, nv: nv, err: err});
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, ".note"},     note,                  e.note);
    chk({tag, ".velocity"}, {1'b0, velocity},      {1'b0, e.vel});
    chk({tag, ".gate"},     {7'd0, gate},          {7'd0, e.gate});
    chk({tag, ".nv"},       {7'd0, note_valid},    {7'd0, e.nv});
    chk({tag, ".err"},      {7'd0, byte_err},      {7'd0, e.err});
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    drive(1'b1, b, 1'b0, 1'b0, tag);
  endtask

  task automatic send_err(input logic [7:0] b, input string tag);
    drive(1'b1, b, 1'b0, 1'b1, tag);
  endtask

  task automatic send_on(input logic [7:0] b, input logic [7:0] n, input logic [6:0] v,
                         input string tag);
    e_note = n;
    e_vel  = v;
    e_gate = 1'b1;
    drive(1'b1, b, 1'b1, 1'b0, tag);
  endtask

  task automatic send_off(input logic [7:0] b, input string tag);
    e_gate = 1'b0;
    drive(1'b1, b, 1'b1, 1'b0, tag);
  endtask

  task automatic idle(input string tag);
    drive(1'b0, 8'h00, 1'b0, 1'b0, tag);
  endtask

  // Reset is asserted between clock edges so that outputs must clear
  // without waiting for a clock.
  task automatic do_reset(input string tag);
    rx_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, ".note"},     note,               8'h00);
    chk({tag, ".velocity"}, {1'b0, velocity},   8'h00);
    chk({tag, ".gate"},     {7'd0, gate},       8'h00);
    chk({tag, ".nv"},       {7'd0, note_valid}, 8'h00);
    chk({tag, ".err"},      {7'd0, byte_err},   8'h00);
    chk({tag, ".o_gate"},   {7'd0, o_gate},     8'h00);
    e_note = 8'd0;
    e_vel  = 7'd0;
    e_gate = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst.note",  note,               8'h00);
    chk("rst.gate",  {7'd0, gate},       8'h00);
    chk("rst.nv",    {7'd0, note_valid}, 8'h00);
    rst_n = 1'b1;
    idle("rst.idle");

    // Basic note-on, pulse lasts one cycle
    send(8'h90, "s1.st");
    send(8'h3C, "s1.d1");
    send_on(8'h64, 8'h3C, 7'h64, "s1.on");
    idle("s1.after");

    // Running status, then velocity-0 note-off
    send(8'h90, "s2.st");
    send(8'h40, "s2.d1a");
    send_on(8'h50, 8'h40, 7'h50, "s2.on_a");
    send(8'h43, "s2.d1b");
    send_on(8'h50, 8'h43, 7'h50, "s2.on_b");
    send(8'h43, "s2.d1c");
    send_off(8'h00, "s2.off");
    idle("s2.after");

    // Mismatched note-off is ignored, matching one releases
    send(8'h90, "s3.st");
    send(8'h45, "s3.d1");
    send_on(8'h7F, 8'h45, 7'h7F, "s3.on");
    send(8'h80, "s3.off_st");
    send(8'h40, "s3.off_d1");
    send(8'h00, "s3.off_miss");
    send(8'h80, "s3.off_st2");
    send(8'h45, "s3.off_d1b");
    send_off(8'h00, "s3.off_hit");
    idle("s3.after");

    // Real-time bytes inside a message
    send(8'h90, "s4.st");
    send(8'hF8, "s4.clk");
    send(8'h3C, "s4.d1");
    send(8'hFE, "s4.sense");
    send_on(8'h64, 8'h3C, 7'h64, "s4.on");
    idle("s4.after");

    // Channel filter; the OMNI instance accepts channel 1
    do_reset("s5.rst");
    send(8'h91, "s5.st1");
    send(8'h3C, "s5.d1");
    send(8'h64, "s5.ch1_skip");
    chk("s5.omni.note", o_note,               8'h3C);
    chk("s5.omni.vel",  {1'b0, o_velocity},   8'h64);
    chk("s5.omni.gate", {7'd0, o_gate},       8'h01);
    chk("s5.omni.nv",   {7'd0, o_note_valid}, 8'h01);
    send(8'hC0, "s5.pc");
    send(8'h05, "s5.pc_d");
    send(8'h90, "s5.st0");
    send(8'h30, "s5.d1b");
    send_on(8'h10, 8'h30, 7'h10, "s5.on");
    idle("s5.after");

    // Reset mid-message, then errors and system-message silence
    send(8'h90, "s6.st");
    send(8'h3C, "s6.d1");
    do_reset("s6.rst");
    send_err(8'h64, "s6.err_a");
    send_err(8'h3C, "s6.err_b");
    send(8'hF0, "s6.sysex");
    send(8'h01, "s6.sx1");
    send(8'h02, "s6.sx2");
    send(8'hF7, "s6.eox");
    send(8'h55, "s6.quiet");
    send(8'h90, "s6.st2");
    send(8'h3C, "s6.d1b");
    send_on(8'h64, 8'h3C, 7'h64, "s6.on");
    idle("s6.after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
